led_matrix_scan: RTL and testbench
==================================

Name: led_matrix_scan

Overview:
- Parametrised multiplexed LED-matrix driver and the successor to the fixed 4x8 column scanner.
- Time-multiplexes NUM_COLS columns of ROWS LEDs onto a shared row bus with active-low one-cold column selects.
- Adds per-slot blanking (anti-ghosting), a global PWM brightness control, a scan enable and a frame-start strobe.
- Sits between display/status logic and the board LED pins.

Parameters:
- NUM_COLS, 4, number of multiplexed columns (>=2).
- ROWS, 8, LEDs per column (width of the row bus).
- SLOT_CYCLES, 65536, clock cycles per column slot (>= BLANK_CYCLES + 2^BRIGHT_BITS).
- BLANK_CYCLES, 64, cycles at the start of each slot with all columns off (>=1).
- BRIGHT_BITS, 4, brightness control width.

Ports:
- clk12MHz  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  scan enable; low forces a dark display.
- brightness  input  BRIGHT_BITS  global PWM duty.
- leds_in  input  NUM_COLS*ROWS  frame data; column c is leds_in[c*ROWS +: ROWS], active high.
- leds  output  ROWS  registered row drive, active high.
- lcol  output  NUM_COLS  registered column select, active low, at most one bit low.
- frame_start  output  1  one-cycle strobe at the start of column 0's slot.

Behaviour:
- Reset (async assert, sync release) sets: leds=0, lcol=all ones, frame_start=0, col=0, slot_cnt=0, state IDLE.
- Internal counters:
  - col: width max(1,$clog2(NUM_COLS)).
  - slot_cnt: width $clog2(SLOT_CYCLES).
- State machine (IDLE, BLANK, DRIVE):
  - IDLE: counters held at 0. Goes to BLANK on the first cycle enable=1.
  - BLANK: active while slot_cnt < BLANK_CYCLES. lcol=all ones, leds=0.
  - DRIVE: active while slot_cnt >= BLANK_CYCLES. lcol has only bit col low. leds = column data when pwm_on, else 0.
  - Any state goes to IDLE when enable=0, on the next edge. Outputs go dark on that edge, counters clear.
- Slot counting:
  - slot_cnt increments every cycle in BLANK/DRIVE.
  - At SLOT_CYCLES-1 it wraps to 0 and col advances.
  - col wraps from NUM_COLS-1 to 0 with no skipped or extra slot. Non-power-of-2 NUM_COLS must wrap explicitly.
- PWM:
  - phase = slot_cnt[BRIGHT_BITS-1:0].
  - pwm_on = (brightness == all ones) | (phase < brightness).
  - brightness=0 gives fully dark rows; lcol still scans.
  - brightness is sampled live; a change takes effect on the next cycle.
- Latency: outputs are registered functions of the current (state, col, slot_cnt, leds_in, brightness), so they appear one edge later.
- frame_start:
  - Asserts for exactly one cycle on the edge where the outputs reflect col=0, slot_cnt=0.
  - This includes the first slot after leaving IDLE.
- No two lcol bits are ever low in the same cycle. Column transitions always pass through BLANK.

Optional Feature:
- Macro: LED_SCAN_SNAPSHOT_EN.
- Defined:
  - An internal NUM_COLS*ROWS frame buffer captures leds_in on the cycle that enters col 0 / slot 0, including the exit from IDLE.
  - The driven data comes only from this buffer, so a frame is always tear-free.
  - The buffer resets to 0.
- Undefined:
  - Column data is taken from leds_in live every cycle.
  - No buffer flops are instantiated.

Decomposition:
- Shared package led_pkg holds:
  - state enum (IDLE, BLANK, DRIVE);
  - the active-low column-select constant LCOL_OFF (all ones);
  - the function col_sel(col) returning the one-cold lcol pattern.
- One natural sub-module: led_pwm_gen (phase and brightness in, pwm_on out, combinational compare). It can be reused by other LED blocks.
- Counters and FSM stay in the top.

Test Plan (NUM_COLS=4, ROWS=8, SLOT_CYCLES=16, BLANK_CYCLES=2, BRIGHT_BITS=2 unless stated):
- Reset/enable:
  - Stimulus: hold resetn=0, then release with enable=0, wait 50 cycles.
  - Required: leds=0x00, lcol=4'b1111, frame_start=0 throughout.
  - Stimulus: raise enable.
  - Required: frame_start pulses once, then 2 cycles lcol=1111, then lcol=1110.
- Scan order:
  - Stimulus: leds_in=0x44332211, brightness=3.
  - Required: DRIVE slots show (leds,lcol) = (0x11,1110), (0x22,1101), (0x33,1011), (0x44,0111), then (0x11,1110) again.
  - Required: frame_start every 64 cycles; never two lcol bits low.
- PWM:
  - brightness=1 -> leds=col data on 1 of each 4 DRIVE cycles, 0x00 otherwise.
  - brightness=0 -> leds=0x00 for the full frame while lcol still scans.
- Enable drop mid-slot:
  - Stimulus: enable=0 at col 2, slot_cnt 7.
  - Required: next edge gives leds=0, lcol=1111.
  - Stimulus: re-enable.
  - Required: restarts at col 0 with frame_start.
- Async reset mid-DRIVE: assert resetn=0 between edges -> outputs go to reset values immediately, without a clock edge.
- LED_SCAN_SNAPSHOT_EN defined:
  - Stimulus: change leds_in from 0x44332211 to 0xDDCCBBAA during col 1.
  - Required: cols 2-3 still show 0x33/0x44; the next frame shows 0xAA..0xDD.

Source files
------------

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the multiplexed LED-matrix scanner family.
//   state_t  : scan state machine encoding (IDLE, BLANK, DRIVE)
//   LCOL_OFF : active-low column-select pattern with every column off
//   col_sel  : one-cold active-low column-select pattern for a column index
// Column patterns are MAX_COLS wide; each user casts them to its own width.
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int MAX_COLS = 32;

    localparam logic [MAX_COLS-1:0] LCOL_OFF = '1;

    function automatic logic [MAX_COLS-1:0] col_sel(input logic [31:0] col);
        return ~(MAX_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// -----------------------------------------------------------------------------
// led_pwm_gen
// Combinational PWM comparator shared by LED driver blocks.
// Ports:
//   phase      in  BRIGHT_BITS  free-running PWM phase
//   brightness in  BRIGHT_BITS  duty setting (all ones = always on)
//   pwm_on     out 1            high while the LED may be lit
// -----------------------------------------------------------------------------
module led_pwm_gen #(
    parameter int BRIGHT_BITS = 4
) (
    input  logic [BRIGHT_BITS-1:0] phase,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic                   pwm_on
);

    // Full scale is forced on so that the top setting gives 100 % duty
    // instead of (2^N-1)/2^N.
    always_comb begin
        pwm_on = (&brightness) | (phase < brightness);
    end

endmodule

// File: rtl/led_matrix_scan.sv
// -----------------------------------------------------------------------------
// led_matrix_scan
// Time-multiplexed LED-matrix driver: NUM_COLS columns of ROWS LEDs share one
// row bus. Each column owns a slot of SLOT_CYCLES clocks; the first
// BLANK_CYCLES of every slot keep all columns off to prevent ghosting. A global
// PWM brightness gates the row data during the drive part of each slot.
// Ports:
//   clk12MHz    in   1               system clock
//   resetn      in   1               asynchronous active-low reset
//   enable      in   1               scan enable (low = dark, counters cleared)
//   brightness  in   BRIGHT_BITS     global PWM duty
//   leds_in     in   NUM_COLS*ROWS   frame data, column c at [c*ROWS +: ROWS]
//   leds        out  ROWS            registered row drive, active high
//   lcol        out  NUM_COLS        registered column select, active low
//   frame_start out  1               one-cycle strobe at start of column 0 slot
// Build option:
//   LED_SCAN_SNAPSHOT_EN  when defined, leds_in is captured into a frame
//                         buffer at the start of every frame and the display
//                         is driven only from that buffer (tear-free frames).
// -----------------------------------------------------------------------------
module led_matrix_scan
    import led_pkg::*;
#(
    parameter int NUM_COLS     = 4,
    parameter int ROWS         = 8,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                     clk12MHz,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    input  logic [NUM_COLS*ROWS-1:0] leds_in,
    output logic [ROWS-1:0]          leds,
    output logic [NUM_COLS-1:0]      lcol,
    output logic                     frame_start
);

    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int SLOT_W = $clog2(SLOT_CYCLES);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [ROWS-1:0]     leds_q, leds_d;
    logic [NUM_COLS-1:0] lcol_q, lcol_d;
    logic                fs_q, fs_d;

    logic [NUM_COLS*ROWS-1:0] src;
    logic [ROWS-1:0]          col_data;
    logic                     pwm_on;

`ifdef LED_SCAN_SNAPSHOT_EN
    logic [NUM_COLS*ROWS-1:0] frame_q, frame_d;
    logic                     frame_load;

    // Load on the edge that moves the scan onto column 0 / slot 0: either
    // leaving IDLE or wrapping out of the last slot of the last column.
    always_comb begin
        frame_load = enable &&
                     ((state_q == IDLE) ||
                      ((slot_q == SLOT_LAST) && (col_q == COL_LAST)));
        frame_d    = frame_load ? leds_in : frame_q;
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign src = frame_q;
`else
    assign src = leds_in;
`endif

    assign col_data = src[32'(col_q)*ROWS +: ROWS];

    led_pwm_gen #(
        .BRIGHT_BITS (BRIGHT_BITS)
    ) u_pwm (
        .phase      (slot_q[BRIGHT_BITS-1:0]),
        .brightness (brightness),
        .pwm_on     (pwm_on)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        slot_d  = slot_q;
        leds_d  = '0;
        lcol_d  = NUM_COLS'(LCOL_OFF);
        fs_d    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            col_d   = '0;
            slot_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
            col_d   = '0;
            slot_d  = '0;
        end else begin
            // Outputs reflect the current position; they appear one edge later.
            fs_d = (col_q == '0) && (slot_q == '0);
            if (state_q == DRIVE) begin
                lcol_d = NUM_COLS'(col_sel(32'(col_q)));
                leds_d = pwm_on ? col_data : '0;
            end

            // Explicit wraps so non-power-of-two sizes never skip or add slots.
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                col_d  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end

            // BLANK/DRIVE follows the slot position, so every column change
            // passes through BLANK.
            state_d = (slot_d < BLANK_END) ? BLANK : DRIVE;
        end
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            col_q   <= '0;
            slot_q  <= '0;
            leds_q  <= '0;
            lcol_q  <= NUM_COLS'(LCOL_OFF);
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            leds_q  <= leds_d;
            lcol_q  <= lcol_d;
            fs_q    <= fs_d;
        end
    end

    assign leds        = leds_q;
    assign lcol        = lcol_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scan
// Bench for led_matrix_scan with NUM_COLS=4, ROWS=8, SLOT_CYCLES=16,
// BLANK_CYCLES=2, BRIGHT_BITS=2. A behavioural model tracks the scan as a
// plain position count since the frame start; directed literal checks pin
// that model at known positions. Honours LED_SCAN_SNAPSHOT_EN.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan;

    localparam int NCOL  = 4;
    localparam int NROW  = 8;
    localparam int SLOT  = 16;
    localparam int BLNK  = 2;
    localparam int BB    = 2;
    localparam int FRAME = NCOL * SLOT;

`ifdef LED_SCAN_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            enable = 1'b0;
    logic [BB-1:0]   brightness = 2'd3;
    logic [31:0]     leds_in = 32'h4433_2211;
    logic [NROW-1:0] leds;
    logic [NCOL-1:0] lcol;
    logic            frame_start;

    int checks = 0;
    int errors = 0;
    int pos    = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    led_matrix_scan #(
        .NUM_COLS     (NCOL),
        .ROWS         (NROW),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLNK),
        .BRIGHT_BITS  (BB)
    ) dut (
        .clk12MHz    (clk),
        .resetn      (resetn),
        .enable      (enable),
        .brightness  (brightness),
        .leds_in     (leds_in),
        .leds        (leds),
        .lcol        (lcol),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // age = cycles since the frame-start position, -1 while idle.
    int              age = -1;
    logic [31:0]     snap = 32'h0;
    logic [NROW-1:0] exp_leds = '0;
    logic [NCOL-1:0] exp_lcol = '1;
    logic            exp_fs = 1'b0;

    always @(posedge clk or negedge resetn) begin
        int p, c, s;
        logic [31:0] data;
        if (!resetn) begin
            exp_leds = '0; exp_lcol = '1; exp_fs = 1'b0;
            age = -1; snap = 32'h0;
        end else if (!enable) begin
            exp_leds = '0; exp_lcol = '1; exp_fs = 1'b0;
            age = -1;
        end else if (age < 0) begin
            exp_leds = '0; exp_lcol = '1; exp_fs = 1'b0;
            age = 0; snap = leds_in;
        end else begin
            p = age % FRAME;
            c = p / SLOT;
            s = p % SLOT;
            data = SNAP ? snap : leds_in;
            exp_fs = (p == 0);
            if (s < BLNK) begin
                exp_lcol = '1;
                exp_leds = '0;
            end else begin
                exp_lcol = ~(4'b0001 << c);
                if (int'(brightness) == (1 << BB) - 1 || (s % (1 << BB)) < int'(brightness))
                    exp_leds = data[c*NROW +: NROW];
                else
                    exp_leds = '0;
            end
            if (p == FRAME - 1) snap = leds_in;
            age++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_leds", 32'(leds), 32'(exp_leds));
            check("model_lcol", 32'(lcol), 32'(exp_lcol));
            check("model_frame_start", 32'(frame_start), 32'(exp_fs));
            check("lcol_one_cold", 32'($countones(~lcol) <= 1), 32'd1);
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic lit(input string name, input logic [7:0] l, input logic [3:0] c, input logic f);
        check({name, "_leds"}, 32'(leds), 32'(l));
        check({name, "_lcol"}, 32'(lcol), 32'(c));
        check({name, "_fs"}, 32'(frame_start), 32'(f));
    endtask

    task automatic goto(input int p);
        while (pos < p) begin
            @(negedge clk);
            pos++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (50) @(negedge clk);
        lit("idle", 8'h00, 4'b1111, 1'b0);

        // Start scanning: one IDLE-exit edge, then frame_start with blanking.
        enable = 1'b1;
        @(negedge clk); lit("en_exit_idle", 8'h00, 4'b1111, 1'b0);
        @(negedge clk); pos = 0; lit("fs_first", 8'h00, 4'b1111, 1'b1);
        goto(1);  lit("blank1", 8'h00, 4'b1111, 1'b0);
        goto(2);  lit("drive_c0_first", 8'h11, 4'b1110, 1'b0);
        goto(8);  lit("scan_c0", 8'h11, 4'b1110, 1'b0);
        goto(24); lit("scan_c1", 8'h22, 4'b1101, 1'b0);
        goto(40); lit("scan_c2", 8'h33, 4'b1011, 1'b0);
        goto(56); lit("scan_c3", 8'h44, 4'b0111, 1'b0);
        goto(63); lit("scan_c3_last", 8'h44, 4'b0111, 1'b0);
        goto(64); lit("fs_second", 8'h00, 4'b1111, 1'b1);
        goto(72); lit("scan_c0_again", 8'h11, 4'b1110, 1'b0);

        // Quarter duty: only phase 0 lights.
        brightness = 2'd1;
        goto(76); lit("pwm1_on", 8'h11, 4'b1110, 1'b0);
        goto(77); lit("pwm1_off_a", 8'h00, 4'b1110, 1'b0);
        goto(78); lit("pwm1_off_b", 8'h00, 4'b1110, 1'b0);
        goto(84); lit("pwm1_c1_on", 8'h22, 4'b1101, 1'b0);
        goto(85); lit("pwm1_c1_off", 8'h00, 4'b1101, 1'b0);

        // Zero brightness: dark rows, columns keep scanning.
        brightness = 2'd0;
        goto(92);  lit("pwm0_c1", 8'h00, 4'b1101, 1'b0);
        goto(104); lit("pwm0_c2", 8'h00, 4'b1011, 1'b0);
        goto(120); lit("pwm0_c3", 8'h00, 4'b0111, 1'b0);

        // Drop enable while the internal position is col 2, slot 7.
        brightness = 2'd3;
        goto(166); lit("pre_drop", 8'h33, 4'b1011, 1'b0);
        enable = 1'b0;
        @(negedge clk); lit("drop", 8'h00, 4'b1111, 1'b0);
        repeat (5) @(negedge clk);
        lit("dropped_idle", 8'h00, 4'b1111, 1'b0);

        // Re-enable restarts at column 0 with a frame strobe.
        enable = 1'b1;
        @(negedge clk); lit("reen_exit_idle", 8'h00, 4'b1111, 1'b0);
        @(negedge clk); pos = 0; lit("fs_restart", 8'h00, 4'b1111, 1'b1);
        goto(2);  lit("restart_c0", 8'h11, 4'b1110, 1'b0);
        goto(20); lit("restart_c1", 8'h22, 4'b1101, 1'b0);

        // New frame data mid-column-1.
        leds_in = 32'hDDCC_BBAA;
        goto(40); lit("newdata_c2", SNAP ? 8'h33 : 8'hCC, 4'b1011, 1'b0);
        goto(56); lit("newdata_c3", SNAP ? 8'h44 : 8'hDD, 4'b0111, 1'b0);
        goto(72); lit("newframe_c0", 8'hAA, 4'b1110, 1'b0);
        goto(88); lit("newframe_c1", 8'hBB, 4'b1101, 1'b0);

        // Asynchronous reset between edges while driving.
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 lit("async_reset", 8'h00, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
